// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU memory bus.
// A 2^ADDR_WIDTH x DATA_WIDTH word store that serves one read or write at a
// time, inserts WAIT_CYCLES wait states and answers with a one-cycle ack.
// With CLEAR_ON_RESET=1 the array is zero-filled, one word per cycle, after reset.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst   - asynchronous reset, active-high
//   req   - access request, sampled only while idle
//   we    - 1 = write, 0 = read, sampled with req
//   addr  - word address, sampled with req
//   data  - write data, sampled with req
//   mem   - read data; valid with ack on a read, held until the next read completes
//   ack   - one-cycle completion pulse
//   busy  - high whenever the responder is not idle
module mem_responder #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned WAIT_CYCLES    = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] mem,
  output logic                  ack,
  output logic                  busy
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned CNT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   init_addr_q, init_addr_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   mem_q, mem_d;
  logic                    ack_q, ack_d;
  logic                    busy_q, busy_d;

  logic [DATA_WIDTH-1:0]   array_q [DEPTH];

  // Array write port, shared by the zero-fill and request writes
  logic                    arr_we;
  logic [ADDR_WIDTH-1:0]   arr_wa;
  logic [DATA_WIDTH-1:0]   arr_wd;

  // Access performed on the edge that enters RESP
  logic                    go;
  logic                    acc_we;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_data;

  // Next-state, datapath and output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_addr_d = init_addr_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mem_d       = mem_q;
    arr_we      = 1'b0;
    arr_wa      = init_addr_q;
    arr_wd      = '0;
    go          = 1'b0;
    acc_we      = we_q;
    acc_addr    = addr_q;
    acc_data    = data_q;

    case (state_q)
      S_INIT: begin
        arr_we      = 1'b1;
        arr_wa      = init_addr_q;
        arr_wd      = '0;
        init_addr_d = init_addr_q + ADDR_WIDTH'(1);
        if (init_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (req) begin
          we_d   = we;
          addr_d = addr;
          data_d = data;
          if (WAIT_CYCLES == 0) begin
            // No wait states: the access uses the inputs being latched now
            state_d  = S_RESP;
            go       = 1'b1;
            acc_we   = we;
            acc_addr = addr;
            acc_data = data;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(CNT_LOAD);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          go      = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (go) begin
      if (acc_we) begin
        arr_we = 1'b1;
        arr_wa = acc_addr;
        arr_wd = acc_data;
      end else begin
        mem_d = array_q[acc_addr];
      end
    end

    ack_d  = (state_d == S_RESP);
    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RESET ? S_INIT : S_IDLE;
      cnt_q       <= '0;
      init_addr_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      mem_q       <= '0;
      ack_q       <= 1'b0;
      busy_q      <= CLEAR_ON_RESET;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_addr_q <= init_addr_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mem_q       <= mem_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  // Storage array, no reset; cleared by the INIT sweep instead
  always_ff @(posedge clk) begin
    if (arr_we) begin
      array_q[arr_wa] <= arr_wd;
    end
  end

  assign mem  = mem_q;
  assign ack  = ack_q;
  assign busy = busy_q;

endmodule
